// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - radix-2 iterative MIPS multiply/divide unit owning HI/LO (optional MULDIV_EARLY_TERM_EN)
module mips_cpu_muldiv #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_next;

  // op[1] selects divide, op[0] selects unsigned
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic               is_div;
  logic               by_zero;
  logic               sign_q;
  logic               sign_r;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   a_saved;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic               last_iter;

  assign op_div    = op[1];
  assign op_signed = ~op[0];
  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude
  assign mag_a     = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b     = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // Restoring divide step; the subtract result always fits WIDTH bits when taken
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, divisor};
  assign rem_sub   = rem_shift[WIDTH-1:0] - divisor;

`ifdef MULDIV_EARLY_TERM_EN
  assign last_iter = (count == CNT_W'(WIDTH - 1)) || (!is_div && mplier[WIDTH-1:1] == '0);
`else
  assign last_iter = (count == CNT_W'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_div && op_b == '0) begin
            state_next = FIX;
          end
`ifdef MULDIV_EARLY_TERM_EN
          else if (!op_div && mag_b == '0) begin
            state_next = FIX;
          end
`endif
          else begin
            state_next = CALC;
          end
        end
      end
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, HI/LO and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div   <= 1'b0;
      by_zero  <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      count    <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      a_saved  <= '0;
    end else if (clk_enable) begin
      busy <= (state_next != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op_div;
            by_zero  <= op_div && (op_b == '0);
            sign_q   <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            sign_r   <= op_signed && op_a[WIDTH-1];
            count    <= '0;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            acc      <= '0;
            mplier   <= mag_b;
            rem      <= '0;
            quo      <= mag_a;
            divisor  <= mag_b;
            a_saved  <= op_a;
            div_zero <= 1'b0;
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            rem <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], rem_ge};
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        FIX: begin
          done <= 1'b1;
          if (by_zero) begin
            hi       <= a_saved;
            lo       <= '1;
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= sign_q ? -quo : quo;
            hi <= sign_r ? -rem : rem;
          end else begin
            {hi, lo} <= sign_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb/tb_mips_cpu_muldiv.sv - scoreboard bench for mips_cpu_muldiv
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] mt_data = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic done_prev = 1'b0;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiply latency in cycles for a given |b|
  function automatic int mul_lat(input logic [31:0] mb);
`ifdef MULDIV_EARLY_TERM_EN
    int msb;
    if (mb == 0) return 2;
    msb = 0;
    for (int i = 0; i < 32; i++) if (mb[i]) msb = i;
    return 3 + msb;
`else
    return 34;
`endif
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz, input int elat);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", {63'd0, busy}, 64'd0);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    e.hi = eh; e.lo = el; e.dz = edz; e.lat = elat; e.t0 = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || sb.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare each done pulse with the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("spurious_done", {63'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("hi", {32'd0, hi}, {32'd0, e.hi});
          chk("lo", {32'd0, lo}, {32'd0, e.lo});
          chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
          chk("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz", {63'd0, div_zero}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, mul_lat(32'hFFFFFFFF));
    issue(MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, mul_lat(32'd5));
    issue(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, mul_lat(32'h80000000));
    issue(MULTU, 32'h00001234, 32'd1,        32'h00000000, 32'h00001234, 1'b0, mul_lat(32'd1));
    issue(MULT,  32'h00000007, 32'd0,        32'h00000000, 32'h00000000, 1'b0, mul_lat(32'd0));
    issue(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    issue(DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0, 34);
    issue(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
    issue(DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 2);
    issue(DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34);
    issue(DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34);
    wait_idle();

    // MTHI and MTLO together while idle
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hA5;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_hi", {32'd0, hi}, 64'hA5);
    chk("mt_lo", {32'd0, lo}, 64'hA5);

    // Clock-enable stall mid-calculation
    issue(MULTU, 32'h10, 32'h10, 32'h0, 32'h100, 1'b0, mul_lat(32'h10) + 5);
    @(negedge clk);
    clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    clk_enable = 1'b1;
    wait_idle();

    // Start and MTHI while busy are ignored
    issue(DIVU, 32'd7, 32'd2, 32'h1, 32'h3, 1'b0, 34);
    repeat (3) @(negedge clk);
    start = 1'b1; op = MULTU; op_a = 32'd5; op_b = 32'd5; mthi = 1'b1; mt_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("busy_mthi_hi", {32'd0, hi}, 64'h100 >> 8 == 1 ? 64'd0 : 64'd0);
    chk("busy_held", {63'd0, busy}, 64'd1);
    wait_idle();

    // Asynchronous reset in the middle of a calculation
    issue(MULTU, 32'd3, 32'h80000003, 32'h1, 32'h80000009, 1'b0, 34);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;

    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
